circle_motion: RTL and testbench

CIRCLE_MOTION -- requirements
Module: circle_motion

---
 rtl/circle_motion.sv | 170 +++++++++++++++++
 tb/tb_circle_motion.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/circle_motion.sv
// circle_motion: moves a circle centre around a 96x64 display, one step per frame.
//
// Modes (mode output): 00 IDLE (centre parked at 48,32), 01 MANUAL (direction
// buttons, clamped at the bounds), 10 AUTO (constant velocity, bouncing off the
// bounds). mode_btn advances IDLE->MANUAL->AUTO->IDLE.
//
// Optional build macro: CIRCLE_MOTION_WRAP_EN -- AUTO wraps to the opposite
// bound instead of bouncing; velocity is then never negated.
//
// Ports:
//   clk                  system clock, rising edge
//   reset                asynchronous active-high reset
//   frame_tick           one-cycle pulse per display frame, the only move event
//   mode_btn             one-cycle debounced pulse, advances the mode
//   btn_up/down/left/right level direction requests, MANUAL only
//   circle_x [6:0]       registered centre column, 0..95
//   circle_y [5:0]       registered centre row, 0..63
//   mode     [1:0]       current mode
//   edge_hit             one-cycle pulse after a move limited/reflected/wrapped at a bound
module circle_motion #(
    parameter int RADIUS = 10,
    parameter int STEP   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       mode_btn,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [6:0] circle_x,
    output logic [5:0] circle_y,
    output logic [1:0] mode,
    output logic       edge_hit
);

    localparam logic signed [8:0] XMIN   = 9'(RADIUS);
    localparam logic signed [8:0] XMAX   = 9'(95 - RADIUS);
    localparam logic signed [8:0] YMIN   = 9'(RADIUS);
    localparam logic signed [8:0] YMAX   = 9'(63 - RADIUS);
    localparam logic signed [8:0] STEP_S = 9'(STEP);
    localparam logic [6:0]        X_HOME = 7'd48;
    localparam logic [5:0]        Y_HOME = 6'd32;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        MANUAL = 2'b01,
        AUTO   = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [6:0]        x_q, x_d;
    logic [5:0]        y_q, y_d;
    logic signed [8:0] vx_q, vx_d, vy_q, vy_d;
    logic              hit_q, hit_d;
    logic signed [8:0] dx, dy, nx, ny;
    logic              x_oob, y_oob;

    // Saturate a candidate position into [lo, hi].
    function automatic logic signed [8:0] clamp_pos(input logic signed [8:0] p,
                                                    input logic signed [8:0] lo,
                                                    input logic signed [8:0] hi);
        if (p < lo)      return lo;
        else if (p > hi) return hi;
        else             return p;
    endfunction

    function automatic logic out_of_range(input logic signed [8:0] p,
                                          input logic signed [8:0] lo,
                                          input logic signed [8:0] hi);
        return (p < lo) || (p > hi);
    endfunction

`ifdef CIRCLE_MOTION_WRAP_EN
    // Leaving through one bound re-enters exactly at the opposite bound.
    function automatic logic signed [8:0] wrap_pos(input logic signed [8:0] p,
                                                   input logic signed [8:0] lo,
                                                   input logic signed [8:0] hi);
        if (p > hi)      return lo;
        else if (p < lo) return hi;
        else             return p;
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        hit_d   = 1'b0;
        dx      = '0;
        dy      = '0;

        // Opposing buttons on one axis leave the delta at zero.
        if (btn_right && !btn_left)      dx = STEP_S;
        else if (btn_left && !btn_right) dx = -STEP_S;
        if (btn_down && !btn_up)         dy = STEP_S;
        else if (btn_up && !btn_down)    dy = -STEP_S;
        if (state_q == AUTO) begin
            dx = vx_q;
            dy = vy_q;
        end

        // Signed 9-bit candidates so a step below column/row 0 stays negative.
        nx    = $signed({2'b00, x_q}) + dx;
        ny    = $signed({3'b000, y_q}) + dy;
        x_oob = out_of_range(nx, XMIN, XMAX);
        y_oob = out_of_range(ny, YMIN, YMAX);

        // A mode change wins over a coincident frame_tick: no move that cycle.
        if (mode_btn) begin
            case (state_q)
                IDLE:    state_d = MANUAL;
                MANUAL:  state_d = AUTO;
                default: begin
                    state_d = IDLE;
                    x_d     = X_HOME;
                    y_d     = Y_HOME;
                end
            endcase
        end else if (frame_tick) begin
            case (state_q)
                MANUAL: begin
                    x_d   = 7'(clamp_pos(nx, XMIN, XMAX));
                    y_d   = 6'(clamp_pos(ny, YMIN, YMAX));
                    hit_d = x_oob || y_oob;
                end
                AUTO: begin
`ifdef CIRCLE_MOTION_WRAP_EN
                    x_d   = 7'(wrap_pos(nx, XMIN, XMAX));
                    y_d   = 6'(wrap_pos(ny, YMIN, YMAX));
`else
                    x_d   = 7'(clamp_pos(nx, XMIN, XMAX));
                    y_d   = 6'(clamp_pos(ny, YMIN, YMAX));
                    if (x_oob) vx_d = -vx_q;
                    if (y_oob) vy_d = -vy_q;
`endif
                    hit_d = x_oob || y_oob;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= X_HOME;
            y_q     <= Y_HOME;
            vx_q    <= STEP_S;
            vy_q    <= STEP_S;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            hit_q   <= hit_d;
        end
    end

    assign circle_x = x_q;
    assign circle_y = y_q;
    assign mode     = state_q;
    assign edge_hit = hit_q;

endmodule

// File: tb/tb_circle_motion.sv
// Testbench for circle_motion: directed scenarios with literal expectations plus a
// randomized phase, all outputs compared every cycle against a behavioural model.
module tb_circle_motion;

    localparam int RADIUS = 10;
    localparam int STEP   = 1;
    localparam int XMIN   = RADIUS;
    localparam int XMAX   = 95 - RADIUS;
    localparam int YMIN   = RADIUS;
    localparam int YMAX   = 63 - RADIUS;

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic       frame_tick = 1'b0;
    logic       mode_btn   = 1'b0;
    logic       btn_up     = 1'b0;
    logic       btn_down   = 1'b0;
    logic       btn_left   = 1'b0;
    logic       btn_right  = 1'b0;
    logic [6:0] circle_x;
    logic [5:0] circle_y;
    logic [1:0] mode;
    logic       edge_hit;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Behavioural model state
    int m_x    = 48;
    int m_y    = 32;
    int m_vx   = STEP;
    int m_vy   = STEP;
    int m_mode = 0;
    bit m_hit  = 1'b0;

    circle_motion #(.RADIUS(RADIUS), .STEP(STEP)) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .mode_btn   (mode_btn),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .circle_x   (circle_x),
        .circle_y   (circle_y),
        .mode       (mode),
        .edge_hit   (edge_hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Manual move: go to the requested spot, but never past a bound.
    task automatic move_clamp(input int p, input int d, input int lo, input int hi,
                              output int np, output bit hit);
        np  = p + d;
        hit = 1'b0;
        if (np > hi) begin np = hi; hit = 1'b1; end
        if (np < lo) begin np = lo; hit = 1'b1; end
    endtask

    // Auto move along one axis with velocity v.
    task automatic move_auto(input int p, input int v, input int lo, input int hi,
                             output int np, output int nv, output bit hit);
        np  = p + v;
        nv  = v;
        hit = 1'b0;
        if (np > hi || np < lo) begin
            hit = 1'b1;
`ifdef CIRCLE_MOTION_WRAP_EN
            np = (np > hi) ? lo : hi;
`else
            np = (np > hi) ? hi : lo;
            nv = -v;
`endif
        end
    endtask

    task automatic model_reset();
        m_x = 48; m_y = 32; m_vx = STEP; m_vy = STEP; m_mode = 0; m_hit = 1'b0;
    endtask

    task automatic model_step();
        bit hx, hy;
        hx = 1'b0;
        hy = 1'b0;
        if (mode_btn) begin
            m_mode = (m_mode + 1) % 3;
            if (m_mode == 0) begin m_x = 48; m_y = 32; end
        end else if (frame_tick && m_mode == 1) begin
            move_clamp(m_x, (btn_right ? STEP : 0) - (btn_left ? STEP : 0), XMIN, XMAX, m_x, hx);
            move_clamp(m_y, (btn_down ? STEP : 0) - (btn_up ? STEP : 0), YMIN, YMAX, m_y, hy);
        end else if (frame_tick && m_mode == 2) begin
            move_auto(m_x, m_vx, XMIN, XMAX, m_x, m_vx, hx);
            move_auto(m_y, m_vy, YMIN, YMAX, m_y, m_vy, hy);
        end
        m_hit = hx | hy;
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) model_reset();
        else       model_step();
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (chk_en) begin
            check("cyc_x",    int'(circle_x), m_x);
            check("cyc_y",    int'(circle_y), m_y);
            check("cyc_mode", int'(mode),     m_mode);
            check("cyc_hit",  int'(edge_hit), int'(m_hit));
        end
    end

    task automatic tick();
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
    endtask

    task automatic press_mode();
        @(negedge clk); mode_btn = 1'b1;
        @(negedge clk); mode_btn = 1'b0;
    endtask

    task automatic collide();
        @(negedge clk); mode_btn = 1'b1; frame_tick = 1'b1;
        @(negedge clk); mode_btn = 1'b0; frame_tick = 1'b0;
    endtask

    task automatic random_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            frame_tick = 1'($urandom_range(0, 1));
            mode_btn   = ($urandom_range(0, 63) == 0);
            btn_up     = 1'($urandom_range(0, 1));
            btn_down   = 1'($urandom_range(0, 1));
            btn_left   = 1'($urandom_range(0, 1));
            btn_right  = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        frame_tick = 1'b0; mode_btn = 1'b0;
        btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;
        check("rst_mode", int'(mode), 0);
        check("rst_x", int'(circle_x), 48);
        check("rst_y", int'(circle_y), 32);
        check("rst_hit", int'(edge_hit), 0);

        press_mode();
        check("mode_manual", int'(mode), 1);

        // Hold left into the XMIN bound
        btn_left = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 38) check("left_x_t38", int'(circle_x), 10);
            if (i == 38) check("left_hit_t38", int'(edge_hit), 0);
            if (i >= 39) check("left_hit_t39_40", int'(edge_hit), 1);
            if (i == 40) check("left_x_t40", int'(circle_x), 10);
            if (i == 40) check("left_y", int'(circle_y), 32);
        end
        btn_left = 1'b0;

        // Opposing vertical buttons cancel
        btn_up = 1'b1; btn_down = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("updn_y", int'(circle_y), 32);
            check("updn_hit", int'(edge_hit), 0);
        end
        btn_up = 1'b0; btn_down = 1'b0;

        press_mode();
        check("mode_auto", int'(mode), 2);
        press_mode();
        check("mode_idle", int'(mode), 0);
        check("idle_home_x", int'(circle_x), 48);
        check("idle_home_y", int'(circle_y), 32);

        press_mode();
        press_mode();
        check("mode_auto2", int'(mode), 2);
        for (int i = 1; i <= 38; i++) begin
            tick();
`ifdef CIRCLE_MOTION_WRAP_EN
            if (i == 21) check("auto_y_t21", int'(circle_y), 53);
            if (i == 22) check("wrap_y_t22", int'(circle_y), 10);
            if (i == 22) check("wrap_hit_t22", int'(edge_hit), 1);
            if (i == 23) check("wrap_y_t23", int'(circle_y), 11);
            if (i == 37) check("wrap_x_t37", int'(circle_x), 85);
            if (i == 38) check("wrap_x_t38", int'(circle_x), 10);
            if (i == 38) check("wrap_hit_t38", int'(edge_hit), 1);
            if (i == 38) check("wrap_y_t38", int'(circle_y), 26);
`else
            if (i == 21) check("auto_y_t21", int'(circle_y), 53);
            if (i == 21) check("auto_x_t21", int'(circle_x), 69);
            if (i == 22) check("bounce_y_t22", int'(circle_y), 53);
            if (i == 22) check("bounce_hit_t22", int'(edge_hit), 1);
            if (i == 23) check("bounce_y_t23", int'(circle_y), 52);
            if (i == 23) check("bounce_hit_t23", int'(edge_hit), 0);
            if (i == 38) check("bounce_x_t38", int'(circle_x), 85);
            if (i == 38) check("bounce_hit_t38", int'(edge_hit), 1);
            if (i == 38) check("bounce_y_t38", int'(circle_y), 37);
`endif
        end

        // mode_btn coinciding with frame_tick: mode advances, no move
        collide();
        check("coll_mode_idle", int'(mode), 0);
        check("coll_home_x", int'(circle_x), 48);
        press_mode();
        btn_right = 1'b1;
        repeat (3) tick();
        check("right_x", int'(circle_x), 51);
        collide();
        check("coll_mode_auto", int'(mode), 2);
        check("coll_x_held", int'(circle_x), 51);
        check("coll_hit", int'(edge_hit), 0);
        btn_right = 1'b0;

        random_cycles(3000);

        // Asynchronous reset in the middle of a cycle with a move pending
        frame_tick = 1'b1;
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("arst_x", int'(circle_x), 48);
        check("arst_y", int'(circle_y), 32);
        check("arst_mode", int'(mode), 0);
        check("arst_hit", int'(edge_hit), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        frame_tick = 1'b0;

        random_cycles(1000);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
